riscv_lsu: RTL and testbench

- Load/store unit sitting directly downstream of the ALU.
- Takes the ALU result as the effective address, plus rs2 store data and funct3.
- Runs one handshaked access on a 32-bit word-addressed data memory port.
- Returns aligned, sign- or zero-extended load data to the writeback mux, or raises an error. One transaction is outstanding at a time; accesses are multi-cycle.

---
 rtl/riscv_lsu_if.sv | 20 ++
 rtl/riscv_lsu.sv | 172 +++++++++++++++++
 tb/tb_riscv_lsu.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_lsu_if.sv
// Data-memory port between the load/store unit (master) and a word-addressed memory (slave).
interface riscv_lsu_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  mem_ready, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output mem_ready, mem_rdata
   );
endinterface

// File: rtl/riscv_lsu.sv
// RV32I load/store unit: one outstanding handshaked access, byte-lane steering,
// load extension, access-error and timeout reporting. All outputs registered.
module riscv_lsu #(
   parameter int TIMEOUT = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               is_store,
   input  logic [2:0]         funct3,
   input  logic [31:0]        addr,
   input  logic [31:0]        wdata,
   output logic               busy,
   output logic               done,
   output logic [31:0]        rdata,
   output logic               err_access,
   output logic               err_timeout,
   riscv_lsu_if.master        mem
);

   typedef enum logic {IDLE, REQ} state_t;

   state_t      state, state_n;
   logic [7:0]  cnt, cnt_n, cnt_inc;
   logic [2:0]  f3_q, f3_n;
   logic [1:0]  lo_q, lo_n;
   logic        we_q, we_n;
   logic [31:0] maddr_q, maddr_n;
   logic [3:0]  be_q, be_n;
   logic [31:0] wd_q, wd_n;
   logic        done_n, ea_n, et_n;
   logic [31:0] rdata_n;

   logic        legal;
   logic [3:0]  be_dec;
   logic [31:0] wd_dec;
   logic [31:0] lane;
   logic [31:0] load_fmt;

   assign cnt_inc       = cnt + 8'd1;
   assign busy          = (state == REQ);
   assign mem.mem_req   = (state == REQ);
   assign mem.mem_we    = we_q;
   assign mem.mem_addr  = maddr_q;
   assign mem.mem_be    = be_q;
   assign mem.mem_wdata = wd_q;

   // Request decode: legality, lane enables and replicated store data.
   always_comb begin
      legal  = 1'b0;
      be_dec = 4'b0000;
      wd_dec = wdata;
      case (funct3)
         3'b000: begin
            legal  = 1'b1;
            be_dec = 4'b0001 << addr[1:0];
            wd_dec = {4{wdata[7:0]}};
         end
         3'b001: begin
            legal  = ~addr[0];
            be_dec = 4'b0011 << addr[1:0];
            wd_dec = {2{wdata[15:0]}};
         end
         3'b010: begin
            legal  = (addr[1:0] == 2'b00);
            be_dec = 4'b1111;
         end
         3'b100: begin
            legal  = ~is_store;
            be_dec = 4'b0001 << addr[1:0];
         end
         3'b101: begin
            legal  = ~is_store & ~addr[0];
            be_dec = 4'b0011 << addr[1:0];
         end
         default: legal = 1'b0;
      endcase
   end

   // Load formatting: shift the addressed lane down, then extend per funct3.
   always_comb begin
      lane = mem.mem_rdata >> {lo_q, 3'b000};
      case (f3_q)
         3'b000:  load_fmt = {{24{lane[7]}}, lane[7:0]};
         3'b001:  load_fmt = {{16{lane[15]}}, lane[15:0]};
         3'b100:  load_fmt = {24'd0, lane[7:0]};
         3'b101:  load_fmt = {16'd0, lane[15:0]};
         default: load_fmt = lane;
      endcase
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      f3_n    = f3_q;
      lo_n    = lo_q;
      we_n    = we_q;
      maddr_n = maddr_q;
      be_n    = be_q;
      wd_n    = wd_q;
      done_n  = 1'b0;
      ea_n    = 1'b0;
      et_n    = 1'b0;
      rdata_n = rdata;
      case (state)
         IDLE: begin
            if (start) begin
               if (!legal) begin
                  done_n = 1'b1;
                  ea_n   = 1'b1;
               end else begin
                  state_n = REQ;
                  cnt_n   = 8'd0;
                  f3_n    = funct3;
                  lo_n    = addr[1:0];
                  we_n    = is_store;
                  maddr_n = {addr[31:2], 2'b00};
                  be_n    = be_dec;
                  wd_n    = wd_dec;
               end
            end
         end
         REQ: begin
            // A response on the timeout edge still counts as success.
            if (mem.mem_ready) begin
               state_n = IDLE;
               done_n  = 1'b1;
               we_n    = 1'b0;
               if (!we_q) rdata_n = load_fmt;
            end else if (cnt_inc == 8'(TIMEOUT)) begin
               state_n = IDLE;
               done_n  = 1'b1;
               et_n    = 1'b1;
               we_n    = 1'b0;
            end else begin
               cnt_n = cnt_inc;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= 8'd0;
         f3_q        <= 3'd0;
         lo_q        <= 2'd0;
         we_q        <= 1'b0;
         maddr_q     <= 32'd0;
         be_q        <= 4'd0;
         wd_q        <= 32'd0;
         done        <= 1'b0;
         err_access  <= 1'b0;
         err_timeout <= 1'b0;
         rdata       <= 32'd0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         f3_q        <= f3_n;
         lo_q        <= lo_n;
         we_q        <= we_n;
         maddr_q     <= maddr_n;
         be_q        <= be_n;
         wd_q        <= wd_n;
         done        <= done_n;
         err_access  <= ea_n;
         err_timeout <= et_n;
         rdata       <= rdata_n;
      end
   end

endmodule

// File: tb/tb_riscv_lsu.sv
// Scoreboard bench for riscv_lsu: byte-level reference memory predicts requests and
// completions; a word memory responder answers the DUT with random or forced latency.
module tb_riscv_lsu;

   localparam int TIMEOUT = 16;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } req_t;

   typedef struct {
      logic        ea;
      logic        et;
      logic [31:0] rdata;
   } done_t;

   logic        clk, rst, start, is_store;
   logic [2:0]  funct3;
   logic [31:0] addr, wdata;
   logic        busy, done, err_access, err_timeout;
   logic [31:0] rdata;

   riscv_lsu_if mem_if();

   riscv_lsu #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .start(start), .is_store(is_store), .funct3(funct3),
      .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
      .err_access(err_access), .err_timeout(err_timeout), .mem(mem_if)
   );

   int compared = 0;
   int mismatched = 0;

   logic [7:0]  ref_mem [0:1023];
   logic [31:0] dmem [0:255];
   logic [31:0] last_rdata;
   req_t        exp_req[$];
   done_t       exp_done[$];

   int force_delay = -1;
   bit idle_noise = 0;
   bit resp_active = 0;
   int wait_cnt, cur_delay;

   bit   prev_req = 0;
   int   req_len = 0, last_req_len = 0;
   req_t held;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog");
   end

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic report_fail(input string name, input string what);
      compared++;
      mismatched++;
      $display("[TB] FAIL %s: got %s, expected none", name, what);
   endtask

   task automatic set_word(input int idx, input logic [31:0] v);
      dmem[idx] = v;
      for (int k = 0; k < 4; k++) ref_mem[idx*4 + k] = v[8*k +: 8];
   endtask

   // Reference model: predicts request fields and completion from byte-level semantics.
   task automatic model_issue(input bit st, input logic [2:0] f, input logic [31:0] a,
                              input logic [31:0] wd, input bit exp_to);
      int size, ai;
      bit legal;
      req_t r;
      logic [31:0] v, mask;
      ai = int'(a[9:0]);
      case (f)
         3'b000, 3'b100: size = 1;
         3'b001, 3'b101: size = 2;
         3'b010:         size = 4;
         default:        size = 0;
      endcase
      legal = (size != 0) && !(st && f[2]) && ((ai % (size == 0 ? 1 : size)) == 0);
      if (!legal) begin
         exp_done.push_back('{1'b1, 1'b0, last_rdata});
         return;
      end
      r.we = st;
      r.addr = {a[31:2], 2'b00};
      r.be = 4'b0000;
      for (int i = 0; i < size; i++) r.be[(ai % 4) + i] = 1'b1;
      for (int k = 0; k < 4; k++) r.wdata[8*k +: 8] = wd[8*(k % size) +: 8];
      exp_req.push_back(r);
      if (exp_to) begin
         exp_done.push_back('{1'b0, 1'b1, last_rdata});
      end else if (st) begin
         for (int i = 0; i < size; i++) ref_mem[ai + i] = wd[8*i +: 8];
         exp_done.push_back('{1'b0, 1'b0, last_rdata});
      end else begin
         v = 32'd0;
         for (int i = 0; i < size; i++) v[8*i +: 8] = ref_mem[ai + i];
         if (size < 4) begin
            mask = (32'd1 << (8*size)) - 32'd1;
            if (!f[2] && v[8*size - 1]) v = v | ~mask;
         end
         last_rdata = v;
         exp_done.push_back('{1'b0, 1'b0, v});
      end
   endtask

   task automatic apply_stimulus(input bit st, input logic [2:0] f, input logic [31:0] a,
                                 input logic [31:0] wd, input bit exp_to);
      int g = 0;
      while (busy && g < 200) begin
         @(negedge clk);
         g++;
      end
      if (busy) report_fail("busy_bound", "busy stuck high");
      start = 1'b1;
      is_store = st;
      funct3 = f;
      addr = a;
      wdata = wd;
      model_issue(st, f, a, wd, exp_to);
      @(negedge clk);
      start = 1'b0;
      addr = $urandom;
      wdata = $urandom;
      funct3 = 3'($urandom_range(0, 7));
      is_store = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_idle();
      int g = 0;
      while ((exp_done.size() != 0 || busy) && g < 100) begin
         @(negedge clk);
         g++;
      end
      if (g >= 100) report_fail("idle_bound", "bound expired with pending done");
   endtask

   // Memory responder: word memory with per-request latency.
   always @(negedge clk) begin
      if (mem_if.mem_req) begin
         if (!resp_active) begin
            resp_active = 1;
            wait_cnt = 0;
            cur_delay = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 4));
         end
         if (wait_cnt == cur_delay) begin
            mem_if.mem_ready = 1'b1;
            mem_if.mem_rdata = dmem[mem_if.mem_addr[9:2]];
            if (mem_if.mem_we)
               for (int k = 0; k < 4; k++)
                  if (mem_if.mem_be[k]) dmem[mem_if.mem_addr[9:2]][8*k +: 8] = mem_if.mem_wdata[8*k +: 8];
         end else begin
            mem_if.mem_ready = 1'b0;
         end
         wait_cnt++;
      end else begin
         resp_active = 0;
         mem_if.mem_ready = idle_noise ? 1'($urandom_range(0, 1)) : 1'b0;
         mem_if.mem_rdata = $urandom;
      end
   end

   // Monitor: pops predicted requests on mem_req rise and predicted completions on done.
   always @(negedge clk) begin
      if (rst) begin
         prev_req = 0;
      end else begin
         if (mem_if.mem_req && !prev_req) begin
            req_len = 1;
            if (exp_req.size() == 0) begin
               report_fail("req_unexpected", "mem_req rise");
            end else begin
               req_t e;
               e = exp_req.pop_front();
               check_output("req_we", 64'(mem_if.mem_we), 64'(e.we));
               check_output("req_addr", 64'(mem_if.mem_addr), 64'(e.addr));
               check_output("req_be", 64'(mem_if.mem_be), 64'(e.be));
               if (e.we) check_output("req_wdata", 64'(mem_if.mem_wdata), 64'(e.wdata));
            end
            held = '{mem_if.mem_we, mem_if.mem_addr, mem_if.mem_be, mem_if.mem_wdata};
         end else if (mem_if.mem_req) begin
            req_len++;
            check_output("req_stable_aw", {mem_if.mem_addr, mem_if.mem_wdata}, {held.addr, held.wdata});
            check_output("req_stable_wb", 64'({mem_if.mem_we, mem_if.mem_be}), 64'({held.we, held.be}));
         end
         if (done) begin
            last_req_len = req_len;
            if (exp_done.size() == 0) begin
               report_fail("done_unexpected", "done pulse");
            end else begin
               done_t d;
               d = exp_done.pop_front();
               check_output("done_err_access", 64'(err_access), 64'(d.ea));
               check_output("done_err_timeout", 64'(err_timeout), 64'(d.et));
               check_output("done_rdata", 64'(rdata), 64'(d.rdata));
            end
         end
         prev_req = mem_if.mem_req;
      end
   end

   initial begin
      rst = 1'b1;
      start = 1'b0;
      is_store = 1'b0;
      funct3 = 3'd0;
      addr = 32'd0;
      wdata = 32'd0;
      last_rdata = 32'd0;
      for (int i = 0; i < 256; i++) set_word(i, $urandom);
      repeat (3) @(negedge clk);

      check_output("rst_busy", 64'(busy), 64'd0);
      check_output("rst_done", 64'(done), 64'd0);
      check_output("rst_err_access", 64'(err_access), 64'd0);
      check_output("rst_err_timeout", 64'(err_timeout), 64'd0);
      check_output("rst_mem_req", 64'(mem_if.mem_req), 64'd0);
      check_output("rst_mem_we", 64'(mem_if.mem_we), 64'd0);
      check_output("rst_mem_addr", 64'(mem_if.mem_addr), 64'd0);
      check_output("rst_mem_be", 64'(mem_if.mem_be), 64'd0);
      check_output("rst_mem_wdata", 64'(mem_if.mem_wdata), 64'd0);
      check_output("rst_rdata", 64'(rdata), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] LB / LBU sign handling");
      set_word(32'h100 >> 2, 32'h80FFEE11);
      apply_stimulus(1'b0, 3'b000, 32'h103, 32'd0, 1'b0);
      wait_idle();
      check_output("lb_rdata", 64'(rdata), 64'hFFFFFF80);
      apply_stimulus(1'b0, 3'b100, 32'h103, 32'd0, 1'b0);
      wait_idle();
      check_output("lbu_rdata", 64'(rdata), 64'h00000080);

      $display("[TB] SH with delayed ready");
      force_delay = 3;
      apply_stimulus(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 1'b0);
      check_output("sh_we", 64'(mem_if.mem_we), 64'd1);
      check_output("sh_addr", 64'(mem_if.mem_addr), 64'h200);
      check_output("sh_be", 64'(mem_if.mem_be), 64'b1100);
      check_output("sh_wdata", 64'(mem_if.mem_wdata), 64'hABCDABCD);
      wait_idle();
      check_output("sh_rdata_kept", 64'(rdata), 64'h00000080);
      force_delay = -1;

      $display("[TB] access errors");
      apply_stimulus(1'b0, 3'b010, 32'h101, 32'd0, 1'b0);
      wait_idle();
      apply_stimulus(1'b0, 3'b011, 32'h100, 32'd0, 1'b0);
      wait_idle();

      $display("[TB] timeout and response on the timeout edge");
      force_delay = 1000;
      apply_stimulus(1'b0, 3'b010, 32'h8, 32'd0, 1'b1);
      wait_idle();
      check_output("timeout_req_len", 64'(last_req_len), 64'(TIMEOUT));
      force_delay = TIMEOUT - 1;
      apply_stimulus(1'b0, 3'b010, 32'h8, 32'd0, 1'b0);
      wait_idle();
      check_output("lastedge_req_len", 64'(last_req_len), 64'(TIMEOUT));
      force_delay = -1;

      $display("[TB] start while busy, then back-to-back start");
      begin
         int g = 0;
         force_delay = 5;
         apply_stimulus(1'b0, 3'b010, 32'h10, 32'd0, 1'b0);
         start = 1'b1;
         is_store = 1'b1;
         funct3 = 3'b010;
         addr = 32'h24;
         wdata = 32'h55AA55AA;
         @(negedge clk);
         start = 1'b0;
         while (!done && g < 50) begin
            @(negedge clk);
            g++;
         end
         if (!done) report_fail("b2b_done_bound", "no done within bound");
         force_delay = -1;
         apply_stimulus(1'b0, 3'b010, 32'h30, 32'd0, 1'b0);
         check_output("b2b_req", 64'(mem_if.mem_req), 64'd1);
         wait_idle();
      end

      $display("[TB] reset during request");
      force_delay = 1000;
      apply_stimulus(1'b0, 3'b010, 32'h0, 32'd0, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      void'(exp_done.pop_back());
      last_rdata = 32'd0;
      check_output("midrst_mem_req", 64'(mem_if.mem_req), 64'd0);
      check_output("midrst_busy", 64'(busy), 64'd0);
      check_output("midrst_done", 64'(done), 64'd0);
      repeat (4) @(negedge clk);
      force_delay = -1;
      set_word(0, 32'hDEADBEEF);
      apply_stimulus(1'b0, 3'b010, 32'h0, 32'd0, 1'b0);
      wait_idle();
      check_output("postrst_rdata", 64'(rdata), 64'hDEADBEEF);

      $display("[TB] randomized traffic");
      idle_noise = 1;
      for (int n = 0; n < 200; n++) begin
         apply_stimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                        32'($urandom_range(0, 1023)), $urandom, 1'b0);
      end
      wait_idle();
      idle_noise = 0;
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
